// File: rtl/ov5640_cfg_pkg.sv
// Shared types and constants for the OV5640 configuration path.
// Holds the arbiter state encoding and the register-write word layout.
package ov5640_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRelease,
    StDone
  } arb_state_e;

  localparam logic [7:0] OV5640_I2C_ADDR = 8'h78;

  // Write word: {dev_addr[7:0], reg_addr[15:0], reg_val[7:0]}
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned DEV_ADDR_LSB = 24;
  localparam int unsigned REG_ADDR_LSB = 8;
  localparam int unsigned REG_VAL_LSB  = 0;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } rr_pick_t;

endpackage

// File: rtl/ov5640_sync_bit.sv
// Single-bit multi-flop synchronizer for signals from the i2c_com clock domain.
module ov5640_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= SYNC_STAGES'({stages, d});
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/ov5640_i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_com write engine between up to four requesters,
// with start/tr_end handshaking, transfer timeout and per-requester completion status.
module ov5640_i2c_arbiter
  import ov5640_cfg_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned DATA_W      = WORD_W,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk_25M,
  input  logic                    camera_rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        nack,
  output logic                    eng_start,
  output logic [DATA_W-1:0]       eng_data,
  input  logic                    eng_tr_end,
  input  logic                    eng_ack,
  output logic                    busy,
  output logic [1:0]              owner,
  output logic                    timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e       state;
  logic [1:0]       rr_ptr;
  logic [N_REQ-1:0] mask;
  logic [CNT_W-1:0] cnt;
  logic             nack_r;
  logic             tr_s;
  logic             ack_s;
  rr_pick_t         pick;

  ov5640_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tr_end (
    .clk (clk_25M),
    .rst (camera_rst),
    .d   (eng_tr_end),
    .q   (tr_s)
  );

  ov5640_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
    .clk (clk_25M),
    .rst (camera_rst),
    .d   (eng_ack),
    .q   (ack_s)
  );

  // First set bit at or after ptr, wrapping; lowest offset wins.
  function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] ptr);
    rr_pick_t p;
    int       k;
    p = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % int'(N_REQ);
      if (r[k]) begin
        p.valid = 1'b1;
        p.idx   = 2'(k);
      end
    end
    return p;
  endfunction

  // The previous owner is hidden for the one IDLE cycle after its done pulse.
  assign pick = rr_pick(req & ~mask, rr_ptr);

  always_ff @(posedge clk_25M) begin
    if (camera_rst) begin
      state       <= StIdle;
      rr_ptr      <= '0;
      mask        <= '0;
      cnt         <= '0;
      nack_r      <= 1'b0;
      eng_start   <= 1'b0;
      eng_data    <= '0;
      done        <= '0;
      nack        <= '0;
      busy        <= 1'b0;
      owner       <= '0;
      timeout_err <= 1'b0;
    end else begin
      done <= '0;
      nack <= '0;
      mask <= '0;
      unique case (state)
        StIdle: begin
          if (pick.valid) begin
            owner    <= pick.idx;
            eng_data <= req_data[int'(pick.idx) * int'(DATA_W) +: DATA_W];
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= StStart;
          end
        end
        StStart: begin
          eng_start <= 1'b1;
          if (tr_s) begin
            nack_r    <= ack_s;
            eng_start <= 1'b0;
            cnt       <= '0;
            state     <= StRelease;
          end else if (cnt == CNT_MAX) begin
            nack_r      <= 1'b1;
            timeout_err <= 1'b1;
            eng_start   <= 1'b0;
            cnt         <= '0;
            state       <= StRelease;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StRelease: begin
          if (!tr_s || cnt == CNT_MAX) begin
            if (tr_s) timeout_err <= 1'b1;
            done[owner] <= 1'b1;
            nack[owner] <= nack_r;
            state       <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDone: begin
          rr_ptr      <= (int'(owner) == int'(N_REQ) - 1) ? 2'd0 : owner + 2'd1;
          mask[owner] <= 1'b1;
          busy        <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_i2c_arbiter.sv
// Directed self-checking bench for ov5640_i2c_arbiter with a behavioural i2c_com model.
module tb_ov5640_i2c_arbiter;

  localparam int unsigned N_REQ = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned TO    = 4000;

  logic              clk_25M = 1'b0;
  logic              camera_rst;
  logic [N_REQ-1:0]  req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]  done;
  logic [N_REQ-1:0]  nack;
  logic              eng_start;
  logic [DW-1:0]     eng_data;
  logic              eng_tr_end = 1'b0;
  logic              eng_ack    = 1'b0;
  logic              busy;
  logic [1:0]        owner;
  logic              timeout_err;

  ov5640_i2c_arbiter #(
    .N_REQ       (N_REQ),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO),
    .SYNC_STAGES (2)
  ) dut (
    .clk_25M     (clk_25M),
    .camera_rst  (camera_rst),
    .req         (req),
    .req_data    (req_data),
    .done        (done),
    .nack        (nack),
    .eng_start   (eng_start),
    .eng_data    (eng_data),
    .eng_tr_end  (eng_tr_end),
    .eng_ack     (eng_ack),
    .busy        (busy),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  always #20 clk_25M = ~clk_25M;

  int cyc = 0;
  always @(posedge clk_25M) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Engine model: tr_end rises eng_delay cycles into a start, falls 3 cycles after start drops.
  int            eng_delay = 20;
  bit            eng_hang  = 1'b0;
  logic [DW-1:0] ack_word  = 32'h7830_0882;
  int            run_cnt   = 0;
  int            low_cnt   = 0;
  int            fall_cyc  = 0;

  always @(negedge clk_25M) begin
    if (eng_start) begin
      low_cnt = 0;
      if (!eng_hang && !eng_tr_end) begin
        run_cnt = run_cnt + 1;
        if (run_cnt >= eng_delay) begin
          eng_tr_end = 1'b1;
          eng_ack    = (eng_data == ack_word);
        end
      end
    end else begin
      run_cnt = 0;
      if (eng_tr_end) begin
        low_cnt = low_cnt + 1;
        if (low_cnt >= 3) begin
          eng_tr_end = 1'b0;
          eng_ack    = 1'b0;
          fall_cyc   = cyc;
        end
      end
    end
  end

  // Event log: 10+i = grant to requester i, 20+i = done to requester i.
  int            ev[$];
  logic [DW-1:0] grant_data[$];
  logic          start_prev = 1'b0;

  always @(negedge clk_25M) begin
    if (eng_start && !start_prev) begin
      ev.push_back(10 + int'(owner));
      grant_data.push_back(eng_data);
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (done[i]) ev.push_back(20 + i);
    end
    start_prev = eng_start;
  end

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!eng_start && n < 10000) begin
      @(negedge clk_25M);
      n++;
    end
    if (!eng_start) check_eq({tag, "_grant_wait"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    @(negedge clk_25M);
    while (done == '0 && n < max_cyc) begin
      @(negedge clk_25M);
      n++;
    end
    if (done == '0) check_eq({tag, "_done_wait"}, 64'd0, 64'd1);
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    req_data[i*DW +: DW] = w;
  endtask

  initial begin
    int cnt;
    int bad;
    int n;
    int exp_ev[8] = '{10, 20, 11, 21, 12, 22, 10, 20};

    camera_rst = 1'b1;
    req        = '0;
    req_data   = '0;
    repeat (3) @(negedge clk_25M);

    check_eq("rst_ctrl", {eng_start, busy, done, nack, owner, timeout_err}, 64'd0);
    check_eq("rst_data", eng_data, 64'd0);
    camera_rst = 1'b0;
    @(negedge clk_25M);

    // Single write from requester 0
    eng_delay = 3000;
    req = 3'b001;
    set_word(0, 32'h7831_0311);
    @(negedge clk_25M);
    check_eq("t1_start_e1", eng_start, 64'd0);
    check_eq("t1_busy", busy, 64'd1);
    check_eq("t1_data", eng_data, 64'h7831_0311);
    @(negedge clk_25M);
    check_eq("t1_start_e2", eng_start, 64'd1);
    wait_done("t1", 5000);
    check_eq("t1_done", done, 64'b001);
    check_eq("t1_nack", nack, 64'b000);
    check_eq("t1_done_lat", cyc - fall_cyc, 64'd3);
    req = '0;
    @(negedge clk_25M);
    check_eq("t1_idle", {busy, done}, 64'd0);

    // Contention: all three request from reset release
    eng_delay  = 20;
    camera_rst = 1'b1;
    req        = 3'b111;
    set_word(0, 32'h7830_0811);
    set_word(1, 32'h7830_0822);
    set_word(2, 32'h7830_0833);
    repeat (2) @(negedge clk_25M);
    ev.delete();
    grant_data.delete();
    camera_rst = 1'b0;
    for (int k = 0; k < 4; k++) wait_done("t2", 500);
    req = '0;
    repeat (5) @(negedge clk_25M);
    check_eq("t2_ev_len", ev.size(), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("t2_ev%0d", k), (k < ev.size()) ? ev[k] : -1, exp_ev[k]);
    end
    check_eq("t2_gdata1", (grant_data.size() > 1) ? grant_data[1] : '0, 64'h7830_0822);

    // NACK from the slave on requester 1
    req = 3'b010;
    set_word(1, 32'h7830_0882);
    wait_done("t3", 500);
    check_eq("t3_done", done, 64'b010);
    check_eq("t3_nack", nack, 64'b010);
    check_eq("t3_toerr", timeout_err, 64'd0);
    req = '0;
    repeat (3) @(negedge clk_25M);

    // Timeout: engine never answers
    eng_hang = 1'b1;
    req = 3'b011;
    set_word(0, 32'h7831_0312);
    set_word(1, 32'h7830_0A00);
    wait_grant("t4");
    check_eq("t4_owner", owner, 64'd0);
    cnt = 0;
    n   = 0;
    while (eng_start && n < int'(TO) + 10) begin
      cnt++;
      n++;
      @(negedge clk_25M);
    end
    check_eq("t4_start_len", cnt, TO - 1);
    wait_done("t4", 50);
    check_eq("t4_done", done, 64'b001);
    check_eq("t4_nack", nack, 64'b001);
    check_eq("t4_toerr", timeout_err, 64'd1);
    eng_hang = 1'b0;
    req = 3'b010;
    wait_grant("t4b");
    check_eq("t4b_owner", owner, 64'd1);
    wait_done("t4b", 500);
    check_eq("t4b_done", done, 64'b010);
    check_eq("t4b_nack", nack, 64'b000);
    check_eq("t4b_sticky", timeout_err, 64'd1);
    req = '0;
    repeat (3) @(negedge clk_25M);

    // Reset in the middle of a transfer owned by requester 2
    eng_delay = 50;
    req = 3'b100;
    set_word(2, 32'h7850_3300);
    wait_grant("t5");
    check_eq("t5_owner", owner, 64'd2);
    camera_rst = 1'b1;
    @(negedge clk_25M);
    check_eq("t5_rst", {eng_start, busy, done, timeout_err}, 64'd0);
    req = 3'b111;
    @(negedge clk_25M);
    camera_rst = 1'b0;
    wait_grant("t5b");
    check_eq("t5b_owner", owner, 64'd0);
    req = 3'b001;
    wait_done("t5b", 500);
    check_eq("t5b_done", done, 64'b001);
    req = '0;
    repeat (3) @(negedge clk_25M);

    // Data stability: req_data changes while requester 2 is being served
    req = 3'b100;
    set_word(2, 32'h7850_3301);
    wait_grant("t6");
    set_word(2, 32'hDEAD_BEEF);
    bad = 0;
    n   = 0;
    while (done == '0 && n < 1000) begin
      @(negedge clk_25M);
      if (eng_data !== 32'h7850_3301) bad++;
      n++;
    end
    check_eq("t6_stable", bad, 64'd0);
    check_eq("t6_done", done, 64'b100);
    check_eq("t6_data", eng_data, 64'h7850_3301);
    req = '0;
    repeat (3) @(negedge clk_25M);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
